axil_selftest_master: RTL and testbench
=======================================

// Module: axil_selftest_master
// PURPOSE
//  Hardware AXI4-Lite master that runs a write-then-readback self-test on the
//  slave register file of myFirstIP. It sits directly upstream of the slave's
//  S00_AXI port, in place of a bus master.
//  On start: writes C_NUM_REGS incrementing words to consecutive word addresses,
//  reads them back, compares each, and reports pass/fail plus an error count.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH   32     address width
//  C_M_AXI_DATA_WIDTH   32     data width (32 only)
//  C_M_TARGET_BASE_ADDR 32'h0  address of register 0
//  C_NUM_REGS           4      registers tested, 1..16
//  C_START_DATA         32'h1  data for register 0; register i gets C_START_DATA+i
// PORTS
//  ACLK           in   1   clock
//  ARESETN        in   1   asynchronous active-low reset
//  start          in   1   1-cycle pulse; begins test when idle
//  busy           out  1   high from accepted start until done
//  done           out  1   1-cycle pulse at test end
//  pass           out  1   level, valid from done until next start: err_count==0
//  err_count      out  8   mismatches + non-OKAY responses, saturates at 255
//  M_AXI_AWADDR   out  AW  write address
//  M_AXI_AWPROT   out  3   tied 3'b000
//  M_AXI_AWVALID  out  1
//  M_AXI_AWREADY  in   1
//  M_AXI_WDATA    out  DW
//  M_AXI_WSTRB    out  DW/8 tied all-ones
//  M_AXI_WVALID   out  1
//  M_AXI_WREADY   in   1
//  M_AXI_BRESP    in   2
//  M_AXI_BVALID   in   1
//  M_AXI_BREADY   out  1
//  M_AXI_ARADDR   out  AW  read address
//  M_AXI_ARPROT   out  3   tied 3'b000
//  M_AXI_ARVALID  out  1
//  M_AXI_ARREADY  in   1
//  M_AXI_RDATA    in   DW
//  M_AXI_RRESP    in   2
//  M_AXI_RVALID   in   1
//  M_AXI_RREADY   out  1
// BEHAVIOUR
//  - Reset: all VALID/READY outputs, busy, done, pass, err_count, index = 0;
//    FSM -> IDLE. Asserting reset mid-transaction drops every VALID
//    immediately (async). No transaction resumes after reset.
//  - FSM: IDLE -> WR -> WR_RESP -> (idx<N-1 ? WR : RD) -> RD_RESP ->
//    (idx<N-1 ? RD : FIN) -> IDLE.
//  - IDLE: start=1 clears err_count and idx, sets busy, goes to WR next cycle.
//    start while busy is ignored.
//  - WR: AWVALID and WVALID rise together in the cycle WR is entered.
//    AWADDR = BASE+4*idx. WDATA = C_START_DATA+idx.
//    Each VALID falls the cycle after its own handshake; AW and W may complete
//    in either order or the same cycle. Address and data stay stable while VALID.
//  - WR_RESP: entered once both AW and W have handshaken. BREADY=1 only in
//    WR_RESP. On BVALID&&BREADY: BRESP!=2'b00 -> err+1, idx+1, next state.
//  - RD: idx reset to 0 on entry from the last write. ARVALID=1, ARADDR=BASE+4*idx.
//    ARVALID falls the cycle after ARREADY.
//  - RD_RESP: RREADY=1. On RVALID: (RDATA!=C_START_DATA+idx) or RRESP!=OKAY
//    -> err+1 (one count per beat max). Then idx+1.
//  - Exactly one transaction outstanding; the next phase issues in the cycle
//    after the prior response handshake.
//  - FIN: done=1 for one cycle, busy=0, pass=(err_count==0), then IDLE.
//  - Data arithmetic wraps modulo 2^DW. err_count saturates at 8'hFF.
//  - Latency with a zero-wait slave: 3 cycles per write, 3 per read, 1 for FIN.
// TESTING
//  1 Zero-wait slave, N=4, START=1: regs 0x0..0xC get 1,2,3,4; reads match;
//    done after 25 cycles; pass=1; err_count=0.
//  2 Slave returns 5 at 0x8: err_count=1, pass=0 at done.
//  3 AWREADY delayed 3 cycles with WREADY immediate (then the reverse):
//    WVALID falls the cycle after its handshake; BREADY not raised until both
//    handshakes complete; data still written correctly.
//  4 Slave BRESP=SLVERR on write 1 and RRESP=SLVERR on read 3 (data good):
//    err_count=2.
//  5 Second start pulse during test ignored; start at done+1 reruns and clears
//    err_count.
//  6 ARESETN low while AWVALID=1: all VALIDs 0 immediately, busy=0; a later
//    start runs the full test cleanly.

Source files
------------

// File: rtl/axil_selftest_master.sv
// AXI4-Lite write-then-readback self-test master.
// Writes C_NUM_REGS words, reads them back, counts mismatches.
module axil_selftest_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_BASE_ADDR = '0,
    parameter int unsigned C_NUM_REGS = 4,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0] C_START_DATA = 1
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [7:0]                      err_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam logic [3:0] LAST_IDX = 4'(C_NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD,
        RD_RESP,
        FIN
    } state_t;

    state_t         state;
    logic [3:0]     idx;
    logic           issued;
    logic           aw_ok;
    logic           w_ok;
    logic           aw_hs;
    logic           w_hs;
    logic           ar_hs;
    logic           b_hs;
    logic           r_hs;
    logic           last;
    logic           rd_bad;
    logic [DW-1:0]  exp_data;
    logic [7:0]     err_inc;

    assign aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs     = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs    = M_AXI_ARVALID && M_AXI_ARREADY;
    assign b_hs     = M_AXI_BVALID && M_AXI_BREADY;
    assign r_hs     = M_AXI_RVALID && M_AXI_RREADY;
    assign last     = (idx == LAST_IDX);
    assign exp_data = C_START_DATA + DW'(idx);
    assign err_inc  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    assign rd_bad   = (M_AXI_RDATA != exp_data) || (M_AXI_RRESP != 2'b00);

    // Address and data follow the index, which only moves on a response
    assign M_AXI_AWADDR = C_M_TARGET_BASE_ADDR + AW'({idx, 2'b00});
    assign M_AXI_ARADDR = C_M_TARGET_BASE_ADDR + AW'({idx, 2'b00});
    assign M_AXI_WDATA  = exp_data;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    // Sequencer: one transaction in flight, next phase issued a cycle after its response
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            idx           <= '0;
            issued        <= 1'b0;
            aw_ok         <= 1'b0;
            w_ok          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        err_count     <= '0;
                        idx           <= '0;
                        busy          <= 1'b1;
                        pass          <= 1'b0;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        issued        <= 1'b1;
                        aw_ok         <= 1'b0;
                        w_ok          <= 1'b0;
                        state         <= WR;
                    end
                end
                WR: begin
                    if (!issued) begin
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        issued        <= 1'b1;
                    end else begin
                        if (aw_hs) begin
                            M_AXI_AWVALID <= 1'b0;
                            aw_ok         <= 1'b1;
                        end
                        if (w_hs) begin
                            M_AXI_WVALID <= 1'b0;
                            w_ok         <= 1'b1;
                        end
                        if ((aw_ok || aw_hs) && (w_ok || w_hs)) begin
                            aw_ok        <= 1'b0;
                            w_ok         <= 1'b0;
                            issued       <= 1'b0;
                            M_AXI_BREADY <= 1'b1;
                            state        <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        M_AXI_BREADY <= 1'b0;
                        if (M_AXI_BRESP != 2'b00) begin
                            err_count <= err_inc;
                        end
                        if (last) begin
                            idx   <= '0;
                            state <= RD;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= WR;
                        end
                    end
                end
                RD: begin
                    if (!issued) begin
                        M_AXI_ARVALID <= 1'b1;
                        issued        <= 1'b1;
                    end else if (ar_hs) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        issued        <= 1'b0;
                        state         <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (r_hs) begin
                        M_AXI_RREADY <= 1'b0;
                        if (rd_bad) begin
                            err_count <= err_inc;
                        end
                        if (last) begin
                            state <= FIN;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= RD;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == 8'd0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_selftest_master.sv
// Bench for axil_selftest_master: behavioural AXI-Lite slave,
// fault plan per run, and an error-count model per run.
module tb_axil_selftest_master;

    localparam int N = 4;
    localparam logic [31:0] START = 32'h1;
    localparam logic [31:0] BASE = 32'h0;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [7:0]  err_count;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY;
    logic        BVALID, BREADY, ARVALID, ARREADY;
    logic        RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    int compared = 0;
    int mismatched = 0;

    always #5 ACLK = ~ACLK;

    axil_selftest_master #(
        .C_M_AXI_ADDR_WIDTH  (32),
        .C_M_AXI_DATA_WIDTH  (32),
        .C_M_TARGET_BASE_ADDR(BASE),
        .C_NUM_REGS          (N),
        .C_START_DATA        (START)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .M_AXI_AWADDR (AWADDR),
        .M_AXI_AWPROT (AWPROT),
        .M_AXI_AWVALID(AWVALID),
        .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA  (WDATA),
        .M_AXI_WSTRB  (WSTRB),
        .M_AXI_WVALID (WVALID),
        .M_AXI_WREADY (WREADY),
        .M_AXI_BRESP  (BRESP),
        .M_AXI_BVALID (BVALID),
        .M_AXI_BREADY (BREADY),
        .M_AXI_ARADDR (ARADDR),
        .M_AXI_ARPROT (ARPROT),
        .M_AXI_ARVALID(ARVALID),
        .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA  (RDATA),
        .M_AXI_RRESP  (RRESP),
        .M_AXI_RVALID (RVALID),
        .M_AXI_RREADY (RREADY)
    );

    // Slave fault plan and delay knobs (written only by the stimulus)
    bit          b_err [16];
    bit          r_err [16];
    bit          c_en  [16];
    logic [31:0] c_val [16];
    int          aw_fix = 0;
    int          w_fix = 0;
    int          ar_fix = 0;
    bit          rand_dly = 0;
    bit          clr = 0;

    // Slave state (written only by the slave process)
    logic [31:0] mem [16];
    int          wr_count = 0;
    logic        aw_got, w_got;
    int          aw_cnt, w_cnt, ar_cnt;
    int          aw_rnd = 0, w_rnd = 0, ar_rnd = 0;
    logic [31:0] aw_lat, w_lat, wa, wd;

    assign AWREADY = AWVALID && !aw_got &&
                     (aw_cnt >= (rand_dly ? aw_rnd : aw_fix));
    assign WREADY  = WVALID && !w_got &&
                     (w_cnt >= (rand_dly ? w_rnd : w_fix));
    assign ARREADY = ARVALID && !RVALID &&
                     (ar_cnt >= (rand_dly ? ar_rnd : ar_fix));

    // Behavioural register-file slave
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_got <= 1'b0; w_got <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            BVALID <= 1'b0; BRESP <= 2'b00;
            RVALID <= 1'b0; RRESP <= 2'b00; RDATA <= '0;
        end else begin
            if (clr) begin
                for (int i = 0; i < 16; i++) mem[i] <= 32'hDEAD_BEEF;
                wr_count <= 0;
            end
            if (AWVALID && !AWREADY) aw_cnt <= aw_cnt + 1;
            if (WVALID && !WREADY) w_cnt <= w_cnt + 1;
            if (ARVALID && !ARREADY) ar_cnt <= ar_cnt + 1;
            if (AWVALID && AWREADY) begin
                aw_got <= 1'b1; aw_lat <= AWADDR; aw_cnt <= 0;
                aw_rnd <= int'($urandom_range(0, 3));
            end
            if (WVALID && WREADY) begin
                w_got <= 1'b1; w_lat <= WDATA; w_cnt <= 0;
                w_rnd <= int'($urandom_range(0, 3));
            end
            if (!BVALID && (aw_got || (AWVALID && AWREADY)) &&
                (w_got || (WVALID && WREADY))) begin
                wa = (AWVALID && AWREADY) ? AWADDR : aw_lat;
                wd = (WVALID && WREADY) ? WDATA : w_lat;
                mem[wa[5:2]] <= wd;
                wr_count <= wr_count + 1;
                BVALID <= 1'b1;
                BRESP <= b_err[wa[5:2]] ? 2'b10 : 2'b00;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (BVALID && BREADY) BVALID <= 1'b0;
            if (ARVALID && ARREADY) begin
                ar_cnt <= 0;
                ar_rnd <= int'($urandom_range(0, 3));
                RVALID <= 1'b1;
                RDATA <= c_en[ARADDR[5:2]] ? c_val[ARADDR[5:2]] : mem[ARADDR[5:2]];
                RRESP <= r_err[ARADDR[5:2]] ? 2'b10 : 2'b00;
            end
            if (RVALID && RREADY) RVALID <= 1'b0;
        end
    end

    // Protocol watcher: counts handshake-rule violations
    int   proto_err = 0;
    logic p_awv = 0, p_wv = 0, p_arv = 0;
    logic p_awh = 0, p_wh = 0, p_arh = 0;
    logic [31:0] p_awa, p_wd, p_ara;
    logic seen_aw = 0, seen_w = 0;
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            p_awv <= 0; p_wv <= 0; p_arv <= 0;
            p_awh <= 0; p_wh <= 0; p_arh <= 0;
            seen_aw <= 0; seen_w <= 0;
        end else begin
            if (p_awh && AWVALID) proto_err <= proto_err + 1;
            if (p_wh && WVALID) proto_err <= proto_err + 1;
            if (p_arh && ARVALID) proto_err <= proto_err + 1;
            if (p_awv && !p_awh && (!AWVALID || AWADDR != p_awa))
                proto_err <= proto_err + 1;
            if (p_wv && !p_wh && (!WVALID || WDATA != p_wd))
                proto_err <= proto_err + 1;
            if (p_arv && !p_arh && (!ARVALID || ARADDR != p_ara))
                proto_err <= proto_err + 1;
            if (BREADY && !(seen_aw && seen_w)) proto_err <= proto_err + 1;
            if ((AWVALID || WVALID) && ARVALID) proto_err <= proto_err + 1;
            if (BVALID && BREADY) begin
                seen_aw <= 0; seen_w <= 0;
            end else begin
                if (AWVALID && AWREADY) seen_aw <= 1;
                if (WVALID && WREADY) seen_w <= 1;
            end
            p_awv <= AWVALID; p_wv <= WVALID; p_arv <= ARVALID;
            p_awh <= AWVALID && AWREADY;
            p_wh  <= WVALID && WREADY;
            p_arh <= ARVALID && ARREADY;
            p_awa <= AWADDR; p_wd <= WDATA; p_ara <= ARADDR;
        end
    end

    // Expected error count from the fault plan
    function automatic int model_err();
        int e = 0;
        logic [31:0] rv;
        for (int i = 0; i < N; i++) begin
            if (b_err[i]) e++;
            rv = c_en[i] ? c_val[i] : START + 32'(i);
            if (r_err[i] || rv != START + 32'(i)) e++;
        end
        return (e > 255) ? 255 : e;
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < 16; i++) begin
            b_err[i] = 0; r_err[i] = 0; c_en[i] = 0; c_val[i] = '0;
        end
        aw_fix = 0; w_fix = 0; ar_fix = 0; rand_dly = 0;
        @(posedge ACLK); #1 clr = 1;
        @(posedge ACLK); #1 clr = 0;
    endtask

    task automatic pulse_start();
        @(posedge ACLK); #1 start = 1;
        @(posedge ACLK); #1 start = 0;
    endtask

    // Starts a run; cyc counts cycles from start assertion to the done cycle
    task automatic run_test(output int cyc, output bit ok, output logic busy0);
        pulse_start();
        busy0 = busy;
        cyc = 1;
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            if (done) begin
                ok = 1;
                break;
            end
            @(posedge ACLK); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        ARESETN = 0;
        repeat (3) @(posedge ACLK);
        #1;
        compared++;
        if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_valids: got %b want 00000",
                     {AWVALID, WVALID, BREADY, ARVALID, RREADY});
        end
        compared++;
        if ({busy, done, pass} !== 3'b0) begin
            mismatched++;
            $display("FAIL reset_status: got %b want 000", {busy, done, pass});
        end
        compared++;
        if (err_count !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_err: got %0d want 0", err_count);
        end
        ARESETN = 1;
        repeat (2) @(posedge ACLK);
        #1;
        compared++;
        if ({busy, AWVALID, WVALID, ARVALID} !== 4'b0) begin
            mismatched++;
            $display("FAIL idle_after_reset: got %b want 0000",
                     {busy, AWVALID, WVALID, ARVALID});
        end
        compared++;
        if ({AWPROT, ARPROT, WSTRB} !== {3'b000, 3'b000, 4'hF}) begin
            mismatched++;
            $display("FAIL tie_offs: got %h want 00f", {AWPROT, ARPROT, WSTRB});
        end
    endtask

    task automatic test_basic();
        int cyc; bit ok; logic b0; int p0;
        clear_plan();
        p0 = proto_err;
        run_test(cyc, ok, b0);
        compared++;
        if (b0 !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_busy: got %b want 1", b0);
        end
        compared++;
        if (!ok || cyc != 6 * N + 1) begin
            mismatched++;
            $display("FAIL basic_latency: got %0d (done=%0d) want %0d",
                     cyc, ok, 6 * N + 1);
        end
        compared++;
        if ({pass, busy, err_count} !== {1'b1, 1'b0, 8'd0}) begin
            mismatched++;
            $display("FAIL basic_result: got pass=%b busy=%b err=%0d want 1 0 0",
                     pass, busy, err_count);
        end
        for (int i = 0; i < N; i++) begin
            compared++;
            if (mem[i] !== START + 32'(i)) begin
                mismatched++;
                $display("FAIL basic_mem%0d: got %h want %h", i, mem[i],
                         START + 32'(i));
            end
        end
        compared++;
        if (wr_count != N) begin
            mismatched++;
            $display("FAIL basic_wrcount: got %0d want %0d", wr_count, N);
        end
        @(posedge ACLK); #1;
        compared++;
        if ({done, pass} !== 2'b01) begin
            mismatched++;
            $display("FAIL basic_done_pulse: got %b want 01", {done, pass});
        end
        compared++;
        if (proto_err != p0) begin
            mismatched++;
            $display("FAIL basic_protocol: got %0d want 0", proto_err - p0);
        end
    endtask

    task automatic test_mismatch();
        int cyc; bit ok; logic b0;
        clear_plan();
        c_en[2] = 1; c_val[2] = 32'd5;
        run_test(cyc, ok, b0);
        compared++;
        if (!ok || err_count !== 8'(model_err()) || pass !== 1'b0) begin
            mismatched++;
            $display("FAIL mismatch: got err=%0d pass=%b want err=%0d pass=0",
                     err_count, pass, model_err());
        end
    endtask

    task automatic test_split_ready();
        int cyc; bit ok; logic b0; int p0;
        for (int pass_i = 0; pass_i < 2; pass_i++) begin
            clear_plan();
            if (pass_i == 0) aw_fix = 3;
            else w_fix = 3;
            p0 = proto_err;
            run_test(cyc, ok, b0);
            compared++;
            if (!ok || err_count !== 8'd0 || pass !== 1'b1) begin
                mismatched++;
                $display("FAIL split_ready%0d: got err=%0d pass=%b want 0 1",
                         pass_i, err_count, pass);
            end
            for (int i = 0; i < N; i++) begin
                compared++;
                if (mem[i] !== START + 32'(i)) begin
                    mismatched++;
                    $display("FAIL split_mem%0d_%0d: got %h want %h", pass_i, i,
                             mem[i], START + 32'(i));
                end
            end
            compared++;
            if (proto_err != p0) begin
                mismatched++;
                $display("FAIL split_protocol%0d: got %0d want 0",
                         pass_i, proto_err - p0);
            end
        end
    endtask

    task automatic test_resp_err();
        int cyc; bit ok; logic b0;
        clear_plan();
        b_err[1] = 1; r_err[3] = 1;
        run_test(cyc, ok, b0);
        compared++;
        if (!ok || err_count !== 8'(model_err()) || pass !== 1'b0) begin
            mismatched++;
            $display("FAIL resp_err: got err=%0d pass=%b want err=%0d pass=0",
                     err_count, pass, model_err());
        end
    endtask

    task automatic test_restart();
        int cyc; int dones; bit ok;
        clear_plan();
        c_en[0] = 1; c_val[0] = 32'h99;
        pulse_start();
        cyc = 1; dones = 0; ok = 0;
        for (int k = 0; k < 2000; k++) begin
            if (done) begin
                ok = 1;
                break;
            end
            if (cyc == 6) start = 1;
            if (cyc == 7) start = 0;
            @(posedge ACLK); #1;
            cyc++;
        end
        compared++;
        if (!ok || cyc != 6 * N + 1 || err_count !== 8'd1) begin
            mismatched++;
            $display("FAIL restart_ignore: got cyc=%0d err=%0d want %0d 1",
                     cyc, err_count, 6 * N + 1);
        end
        c_en[0] = 0;
        pulse_start();
        compared++;
        if ({busy, err_count} !== {1'b1, 8'd0}) begin
            mismatched++;
            $display("FAIL restart_clear: got busy=%b err=%0d want 1 0",
                     busy, err_count);
        end
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            if (done) begin
                ok = 1;
                dones++;
                break;
            end
            @(posedge ACLK); #1;
        end
        compared++;
        if (!ok || pass !== 1'b1 || err_count !== 8'd0) begin
            mismatched++;
            $display("FAIL restart_rerun: got done=%0d pass=%b err=%0d want 1 1 0",
                     dones, pass, err_count);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit ok; logic b0; int p0;
        clear_plan();
        aw_fix = 3;
        pulse_start();
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (AWVALID) begin
                ok = 1;
                break;
            end
            @(posedge ACLK); #1;
        end
        @(posedge ACLK); #1;
        ARESETN = 0;
        #1;
        compared++;
        if (!ok || {AWVALID, WVALID, BREADY, ARVALID, RREADY, busy} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_mid: got %b (seen=%0d) want 000000",
                     {AWVALID, WVALID, BREADY, ARVALID, RREADY, busy}, ok);
        end
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1;
        clear_plan();
        repeat (3) @(posedge ACLK);
        #1;
        compared++;
        if ({AWVALID, WVALID, ARVALID, busy} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_no_resume: got %b want 0000",
                     {AWVALID, WVALID, ARVALID, busy});
        end
        p0 = proto_err;
        run_test(cyc, ok, b0);
        compared++;
        if (!ok || cyc != 6 * N + 1 || err_count !== 8'd0 || pass !== 1'b1 ||
            wr_count != N || proto_err != p0) begin
            mismatched++;
            $display("FAIL reset_rerun: got cyc=%0d err=%0d pass=%b wr=%0d want %0d 0 1 %0d",
                     cyc, err_count, pass, wr_count, 6 * N + 1, N);
        end
    endtask

    task automatic test_random();
        int cyc; bit ok; logic b0; int p0; int exp_e; int bad_mem;
        for (int it = 0; it < 8; it++) begin
            clear_plan();
            rand_dly = 1;
            for (int i = 0; i < N; i++) begin
                b_err[i] = ($urandom_range(0, 3) == 0);
                r_err[i] = ($urandom_range(0, 3) == 0);
                c_en[i]  = ($urandom_range(0, 2) == 0);
                c_val[i] = 32'($urandom_range(0, 6));
            end
            exp_e = model_err();
            p0 = proto_err;
            run_test(cyc, ok, b0);
            compared++;
            if (!ok || err_count !== 8'(exp_e) || pass !== (exp_e == 0)) begin
                mismatched++;
                $display("FAIL random%0d: got err=%0d pass=%b want err=%0d pass=%0d",
                         it, err_count, pass, exp_e, exp_e == 0);
            end
            bad_mem = 0;
            for (int i = 0; i < N; i++)
                if (mem[i] !== START + 32'(i)) bad_mem++;
            compared++;
            if (bad_mem != 0 || proto_err != p0) begin
                mismatched++;
                $display("FAIL random%0d_mem_proto: got bad=%0d proto=%0d want 0 0",
                         it, bad_mem, proto_err - p0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_split_ready();
        test_resp_err();
        test_restart();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
